// File: rtl/imem_loader_if.sv
// Byte-stream input and RAM write port of the instruction-memory loader.
// master = the loader itself, slave = the byte source / RAM side.
interface imem_loader_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;

    modport master (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output we,
        output wa,
        output wd
    );

    modport slave (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  we,
        input  wa,
        input  wd
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction RAM loader: packs a little-endian byte stream into 32-bit words,
// writes them to word addresses 0..N-1 and holds the CPU for the duration.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   word_count,
    imem_loader_if.master     bus,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_WRITE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [ADDR_W:0]   CAP       = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DATA_W-1:0] WORD_ZERO = {DATA_W{1'b0}};

    logic [1:0]        state_r, state_s;
    logic [ADDR_W:0]   count_r, count_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [1:0]        lane_r, lane_s;
    logic [DATA_W-1:0] word_r, word_s;
    logic [ADDR_W-1:0] wa_r, wa_s;
    logic [DATA_W-1:0] wd_r, wd_s;
    logic              err_r, err_s;
    logic              byte_ready_r, byte_ready_s;
    logic              we_r, we_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              accept_s;
    logic              last_word_s;

    assign accept_s    = bus.byte_valid & byte_ready_r;
    assign last_word_s = ({1'b0, addr_r} == (count_r - CNT_ONE));

    // Next-state logic; outputs are derived from the next state so they come out registered.
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        addr_s  = addr_r;
        lane_s  = lane_r;
        word_s  = word_r;
        wa_s    = wa_r;
        wd_s    = wd_r;
        err_s   = err_r;

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    addr_s = ADDR_ZERO;
                    lane_s = 2'd0;
                    word_s = WORD_ZERO;
                    // Oversized loads are clamped to capacity so the address never wraps.
                    if (word_count > CAP) begin
                        count_s = CAP;
                        err_s   = 1'b1;
                    end else begin
                        count_s = word_count;
                        err_s   = 1'b0;
                    end
                    if (word_count == CNT_ZERO) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end else begin
                    state_s = state_r;
                end
            end

            ST_COLLECT: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (accept_s) begin
                    word_s[{lane_r, 3'b000} +: 8] = bus.byte_data;
                    if (lane_r == 2'd3) begin
                        state_s = ST_WRITE;
                        wa_s    = addr_r;
                        wd_s    = word_s;
                    end else begin
                        lane_s = lane_r + 2'd1;
                    end
                end else begin
                    state_s = ST_COLLECT;
                end
            end

            ST_WRITE: begin
                if (abort) begin
                    state_s = ST_IDLE;
                end else if (last_word_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_COLLECT;
                    addr_s  = addr_r + ADDR_ONE;
                    lane_s  = 2'd0;
                    word_s  = WORD_ZERO;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        byte_ready_s = (state_s == ST_COLLECT);
        we_s         = (state_s == ST_WRITE);
        busy_s       = (state_s == ST_COLLECT) || (state_s == ST_WRITE);
        done_s       = (state_s == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            count_r      <= CNT_ZERO;
            addr_r       <= ADDR_ZERO;
            lane_r       <= 2'd0;
            word_r       <= WORD_ZERO;
            wa_r         <= ADDR_ZERO;
            wd_r         <= WORD_ZERO;
            err_r        <= 1'b0;
            byte_ready_r <= 1'b0;
            we_r         <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            count_r      <= count_s;
            addr_r       <= addr_s;
            lane_r       <= lane_s;
            word_r       <= word_s;
            wa_r         <= wa_s;
            wd_r         <= wd_s;
            err_r        <= err_s;
            byte_ready_r <= byte_ready_s;
            we_r         <= we_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign bus.byte_ready = byte_ready_r;
    assign bus.we         = we_r;
    assign bus.wa         = wa_r;
    assign bus.wd         = wd_r;
    assign busy           = busy_r;
    assign cpu_hold       = busy_r;
    assign done           = done_r;
    assign err            = err_r;

endmodule
